spmv_mem_arbiter: RTL and testbench

//  Shares the single PE memory port (ld/st, 48b addr, 64b d_or_tag, 3b rsp tag) among NUM_REQ PE-internal

---
 rtl/spmv_mem_arbiter.sv | 231 +++++++++++++++++++++++
 tb/tb_spmv_mem_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spmv_mem_arbiter.sv
// Shares one PE memory port among NUM_REQ requesters: per-requester FIFOs, round-robin grant,
// requester ID folded into the memory tag and used to route load responses. Optional: SPMV_MEM_ARB_STATS_EN.
module spmv_mem_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned REQ_TAG_W  = 1,
  parameter int unsigned FIFO_DEPTH = 4,
  localparam int unsigned ADDR_W    = 48,
  localparam int unsigned DATA_W    = 64,
  localparam int unsigned MTAG_W    = ID_W + REQ_TAG_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_ld,
  input  logic [NUM_REQ-1:0]          req_st,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_d_or_tag,
  output logic [NUM_REQ-1:0]          req_stall,
  output logic [NUM_REQ-1:0]          rsp_push,
  output logic [REQ_TAG_W-1:0]        rsp_tag,
  output logic [DATA_W-1:0]           rsp_q,
  input  logic [NUM_REQ-1:0]          rsp_stall,
  output logic                        req_mem_ld,
  output logic                        req_mem_st,
  output logic [ADDR_W-1:0]           req_mem_addr,
  output logic [DATA_W-1:0]           req_mem_d_or_tag,
  input  logic                        req_mem_stall,
  input  logic                        rsp_mem_push,
  input  logic [MTAG_W-1:0]           rsp_mem_tag,
  input  logic [DATA_W-1:0]           rsp_mem_q,
  output logic                        rsp_mem_stall,
  output logic                        busy,
`ifdef SPMV_MEM_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0]       grant_count,
  output logic [31:0]                 stall_cycles,
`endif
  output logic                        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // FIFO storage (no reset needed: occupancy is tracked by the counters)
  logic              st_mem   [NUM_REQ][FIFO_DEPTH];
  logic [ADDR_W-1:0] addr_mem [NUM_REQ][FIFO_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_REQ][FIFO_DEPTH];

  logic [CNT_W-1:0] cnt_q [NUM_REQ];
  logic [CNT_W-1:0] cnt_d [NUM_REQ];
  logic [PTR_W-1:0] wr_q  [NUM_REQ];
  logic [PTR_W-1:0] wr_d  [NUM_REQ];
  logic [PTR_W-1:0] rd_q  [NUM_REQ];
  logic [PTR_W-1:0] rd_d  [NUM_REQ];

  logic [ID_W-1:0]    rr_q, rr_d, idx, grant_id;
  logic               grant_vld;
  logic [NUM_REQ-1:0] push_v, full, wr_en, pop;
  logic [NUM_REQ-1:0] stall_q, stall_d;
  logic               ovf_q, ovf_d, busy_q, busy_d;

  logic               sel_st;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               mem_ld_q, mem_ld_d, mem_st_q, mem_st_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_data_q, mem_data_d;

  logic [NUM_REQ-1:0]   rsp_push_q, rsp_push_d;
  logic [REQ_TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic [DATA_W-1:0]    rsp_q_q, rsp_q_d;

  // Round-robin search starting just after the last winner
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = '0;
    if (!req_mem_stall) begin
      for (int k = 1; k <= int'(NUM_REQ); k++) begin
        idx = rr_q + ID_W'(k);
        if (!grant_vld && (cnt_q[idx] != '0)) begin
          grant_vld = 1'b1;
          grant_id  = idx;
        end
      end
    end
    rr_d = grant_vld ? grant_id : rr_q;
  end

  // FIFO bookkeeping; a push into a full FIFO is dropped and flagged
  always_comb begin
    ovf_d   = ovf_q;
    busy_d  = grant_vld;
    push_v  = '0;
    full    = '0;
    wr_en   = '0;
    pop     = '0;
    stall_d = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      push_v[i]  = req_ld[i] | req_st[i];
      full[i]    = (cnt_q[i] == CNT_W'(FIFO_DEPTH));
      wr_en[i]   = push_v[i] & ~full[i];
      pop[i]     = grant_vld && (grant_id == ID_W'(i));
      cnt_d[i]   = cnt_q[i] + CNT_W'(wr_en[i]) - CNT_W'(pop[i]);
      wr_d[i]    = wr_q[i] + PTR_W'(wr_en[i]);
      rd_d[i]    = rd_q[i] + PTR_W'(pop[i]);
      stall_d[i] = (cnt_d[i] >= CNT_W'(FIFO_DEPTH - 2));
      if (push_v[i] && full[i]) ovf_d = 1'b1;
      if (cnt_d[i] != '0) busy_d = 1'b1;
    end
  end

  // Memory request: loads carry {ID, requester tag}, stores pass data through
  always_comb begin
    sel_st     = st_mem[grant_id][rd_q[grant_id]];
    sel_addr   = addr_mem[grant_id][rd_q[grant_id]];
    sel_data   = data_mem[grant_id][rd_q[grant_id]];
    mem_ld_d   = grant_vld && !sel_st;
    mem_st_d   = grant_vld && sel_st;
    mem_addr_d = grant_vld ? sel_addr : '0;
    mem_data_d = '0;
    if (grant_vld) begin
      mem_data_d = sel_st ? sel_data : DATA_W'({grant_id, sel_data[REQ_TAG_W-1:0]});
    end
  end

  // Stateless response routing by the ID field of the tag
  always_comb begin
    rsp_push_d = '0;
    rsp_tag_d  = '0;
    rsp_q_d    = '0;
    if (rsp_mem_push) begin
      rsp_push_d[rsp_mem_tag[MTAG_W-1 -: ID_W]] = 1'b1;
      rsp_tag_d = rsp_mem_tag[REQ_TAG_W-1:0];
      rsp_q_d   = rsp_mem_q;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (wr_en[i]) begin
        st_mem[i][wr_q[i]]   <= req_st[i];
        addr_mem[i][wr_q[i]] <= req_addr[ADDR_W*i +: ADDR_W];
        data_mem[i][wr_q[i]] <= req_d_or_tag[DATA_W*i +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        cnt_q[i] <= '0;
        wr_q[i]  <= '0;
        rd_q[i]  <= '0;
      end
      rr_q       <= ID_W'(NUM_REQ - 1);
      stall_q    <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      mem_ld_q   <= 1'b0;
      mem_st_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      rsp_push_q <= '0;
      rsp_tag_q  <= '0;
      rsp_q_q    <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        cnt_q[i] <= cnt_d[i];
        wr_q[i]  <= wr_d[i];
        rd_q[i]  <= rd_d[i];
      end
      rr_q       <= rr_d;
      stall_q    <= stall_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      mem_ld_q   <= mem_ld_d;
      mem_st_q   <= mem_st_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      rsp_push_q <= rsp_push_d;
      rsp_tag_q  <= rsp_tag_d;
      rsp_q_q    <= rsp_q_d;
    end
  end

`ifdef SPMV_MEM_ARB_STATS_EN
  logic [31:0] gcnt_q [NUM_REQ];
  logic [31:0] scyc_q;

  // Saturating counters
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_REQ); i++) gcnt_q[i] <= '0;
      scyc_q <= '0;
    end else begin
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (pop[i] && (gcnt_q[i] != '1)) gcnt_q[i] <= gcnt_q[i] + 32'd1;
      end
      if (req_mem_stall && busy_any() && (scyc_q != '1)) scyc_q <= scyc_q + 32'd1;
    end
  end

  function automatic logic busy_any();
    logic any;
    any = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (cnt_q[i] != '0) any = 1'b1;
    end
    return any;
  endfunction

  always_comb begin
    grant_count = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) grant_count[32*i +: 32] = gcnt_q[i];
  end
  assign stall_cycles = scyc_q;
`endif

  assign req_stall        = stall_q;
  assign rsp_push         = rsp_push_q;
  assign rsp_tag          = rsp_tag_q;
  assign rsp_q            = rsp_q_q;
  assign req_mem_ld       = mem_ld_q;
  assign req_mem_st       = mem_st_q;
  assign req_mem_addr     = mem_addr_q;
  assign req_mem_d_or_tag = mem_data_q;
  assign rsp_mem_stall    = |rsp_stall;
  assign busy             = busy_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed bench for spmv_mem_arbiter: reset, load round trip, RR order, stall/back-pressure, store, overflow.
module tb_spmv_mem_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_ld, req_st;
  logic [191:0] req_addr;
  logic [255:0] req_d_or_tag;
  logic [3:0]   req_stall, rsp_push, rsp_stall;
  logic [0:0]   rsp_tag;
  logic [63:0]  rsp_q;
  logic         req_mem_ld, req_mem_st, req_mem_stall;
  logic [47:0]  req_mem_addr;
  logic [63:0]  req_mem_d_or_tag, rsp_mem_q;
  logic         rsp_mem_push, rsp_mem_stall, busy, overflow;
  logic [2:0]   rsp_mem_tag;
`ifdef SPMV_MEM_ARB_STATS_EN
  logic [127:0] grant_count;
  logic [31:0]  stall_cycles;
`endif

  int errors = 0;
  int checks = 0;

  spmv_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req_ld(req_ld), .req_st(req_st), .req_addr(req_addr), .req_d_or_tag(req_d_or_tag),
    .req_stall(req_stall), .rsp_push(rsp_push), .rsp_tag(rsp_tag), .rsp_q(rsp_q),
    .rsp_stall(rsp_stall), .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
    .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
    .req_mem_stall(req_mem_stall), .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag),
    .rsp_mem_q(rsp_mem_q), .rsp_mem_stall(rsp_mem_stall), .busy(busy),
`ifdef SPMV_MEM_ARB_STATS_EN
    .grant_count(grant_count), .stall_cycles(stall_cycles),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs set after this are sampled at the next edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_ld = '0; req_st = '0; req_addr = '0; req_d_or_tag = '0;
    rsp_stall = '0; req_mem_stall = 1'b0;
    rsp_mem_push = 1'b0; rsp_mem_tag = '0; rsp_mem_q = '0;
  endtask

  task automatic set_req(input int i, input logic ld, input logic st,
                         input logic [47:0] a, input logic [63:0] d);
    req_ld[i] = ld;
    req_st[i] = st;
    req_addr[48*i +: 48] = a;
    req_d_or_tag[64*i +: 64] = d;
  endtask

  task automatic check_grant(input string tag, input logic ld, input logic st,
                             input logic [47:0] a, input logic [63:0] d);
    check({tag, ".ld"}, 64'(req_mem_ld), 64'(ld));
    check({tag, ".st"}, 64'(req_mem_st), 64'(st));
    check({tag, ".addr"}, 64'(req_mem_addr), 64'(a));
    check({tag, ".d"}, req_mem_d_or_tag, d);
  endtask

  initial begin
    clear_inputs();
    // 1: reset with random inputs
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      req_ld = 4'($urandom); req_st = 4'($urandom);
      req_addr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      req_d_or_tag = {8{$urandom}};
      rsp_mem_push = 1'b1; rsp_mem_tag = 3'($urandom); rsp_mem_q = {$urandom, $urandom};
      req_mem_stall = 1'($urandom);
      tick();
    end
    check("rst.mem_ld", 64'(req_mem_ld), 64'd0);
    check("rst.mem_st", 64'(req_mem_st), 64'd0);
    check("rst.addr", 64'(req_mem_addr), 64'd0);
    check("rst.d", req_mem_d_or_tag, 64'd0);
    check("rst.rsp_push", 64'(rsp_push), 64'd0);
    check("rst.rsp_tag", 64'(rsp_tag), 64'd0);
    check("rst.rsp_q", rsp_q, 64'd0);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.req_stall", 64'(req_stall), 64'd0);
    check("rst.overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    clear_inputs();
    tick();
    check("idle.busy", 64'(busy), 64'd0);

    // 3: simultaneous loads on all requesters -> 0,1,2,3 then again from 0
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b0, 48'(32'h100 * (i + 1) + 32'h10 * b), 64'(i % 2));
      tick();
      clear_inputs();
      check("rr.no_early", 64'(req_mem_ld), 64'd0);
      for (int i = 0; i < 4; i++) begin
        tick();
        check_grant($sformatf("rr%0d.g%0d", b, i), 1'b1, 1'b0,
                    48'(32'h100 * (i + 1) + 32'h10 * b), 64'(i * 2 + i % 2));
        check($sformatf("rr%0d.busy%0d", b, i), 64'(busy), 64'd1);
      end
      tick();
      check("rr.idle_ld", 64'(req_mem_ld), 64'd0);
      check("rr.idle_busy", 64'(busy), 64'd0);
    end

    // 2: single load round trip
    set_req(0, 1'b1, 1'b0, 48'h1000, 64'd1);
    tick();
    clear_inputs();
    check("ld.lat1", 64'(req_mem_ld), 64'd0);
    tick();
    check_grant("ld", 1'b1, 1'b0, 48'h1000, 64'b001);
    rsp_mem_push = 1'b1; rsp_mem_tag = 3'b001; rsp_mem_q = 64'hDEAD;
    tick();
    clear_inputs();
    check("ld.pulse", 64'(req_mem_ld), 64'd0);
    check("rsp.push", 64'(rsp_push), 64'b0001);
    check("rsp.tag", 64'(rsp_tag), 64'd1);
    check("rsp.q", rsp_q, 64'hDEAD);
    tick();
    check("rsp.push_off", 64'(rsp_push), 64'd0);
    check("rsp.q_off", rsp_q, 64'd0);
    check("rsp.tag_off", 64'(rsp_tag), 64'd0);

    // 4: memory stall for 5 cycles while req1 queues 3 loads
    req_mem_stall = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j < 3) set_req(1, 1'b1, 1'b0, 48'(32'hA000 + 8 * j), 64'(j % 2));
      else set_req(1, 1'b0, 1'b0, 48'd0, 64'd0);
      tick();
      check($sformatf("stall.no_ld%0d", j), 64'(req_mem_ld), 64'd0);
      check($sformatf("stall.req_stall%0d", j), 64'(req_stall[1]), 64'(j >= 1));
    end
    clear_inputs();
    for (int j = 0; j < 3; j++) begin
      tick();
      check_grant($sformatf("stall.g%0d", j), 1'b1, 1'b0, 48'(32'hA000 + 8 * j), 64'(2 + j % 2));
    end
    check("stall.req_stall_end", 64'(req_stall[1]), 64'd0);
    check("stall.overflow", 64'(overflow), 64'd0);

    // 5: store with ld also asserted: store wins, data unchanged
    set_req(2, 1'b1, 1'b1, 48'h2008, 64'h3FF0000000000000);
    tick();
    clear_inputs();
    tick();
    check_grant("st", 1'b0, 1'b1, 48'h2008, 64'h3FF0000000000000);
    check("st.rsp_push", 64'(rsp_push), 64'd0);
    tick();
    check("st.pulse", 64'(req_mem_st), 64'd0);

    // 6: response back-pressure and overflow
    rsp_stall = 4'b1000;
    #1;
    check("rsp_mem_stall.on", 64'(rsp_mem_stall), 64'd1);
    rsp_stall = 4'b0000;
    #1;
    check("rsp_mem_stall.off", 64'(rsp_mem_stall), 64'd0);
    req_mem_stall = 1'b1;
    for (int j = 0; j < 5; j++) begin
      set_req(3, 1'b1, 1'b0, 48'(32'hC000 + 8 * j), 64'd0);
      tick();
      check($sformatf("ovf.push%0d", j), 64'(overflow), 64'(j == 4));
    end
    clear_inputs();
    for (int j = 0; j < 4; j++) begin
      tick();
      check_grant($sformatf("ovf.g%0d", j), 1'b1, 1'b0, 48'(32'hC000 + 8 * j), 64'd6);
    end
    tick();
    check("ovf.drained", 64'(req_mem_ld), 64'd0);
    check("ovf.sticky", 64'(overflow), 64'd1);
    check("ovf.busy", 64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
